fifo_thresh: RTL and testbench

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It replaces the basic fixed-behaviour FIFO as the standard buffering element between producer/consumer blocks sharing one clock. The chip-select-gated write/read interface is kept, so existing producers and consumers attach unchanged.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 34 +++
 rtl/fifo_thresh.sv | 130 +++++++++++++
 tb/tb_fifo_thresh.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the fifo_thresh family.
//   ptr_width(depth)   - bits needed to address 'depth' entries.
//   count_width(depth) - bits needed to hold an occupancy of 0..depth.
//   MODE_STD / MODE_FWFT - values for the FWFT parameter of fifo_thresh.
package fifo_pkg;

  localparam int MODE_STD  = 0;  // registered read, data one cycle after pop
  localparam int MODE_FWFT = 1;  // head entry visible on data_out while !empty

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port register array backing the FIFO.
//   clk   - write clock (rising edge)
//   we    - write enable; stores wdata at waddr on the edge
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - contents of mem[raddr], combinational
// Contents are intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh.sv
// fifo_thresh: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
//   clk, rst_n     - clock; asynchronous active-low reset
//   cs             - chip select; wr_en/rd_en are ignored while low
//   wr_en, data_in - write request and data
//   rd_en          - read (pop) request
//   clr_err        - clears overflow/underflow (a same-cycle set wins)
//   data_out       - read data (registered in standard mode, head entry in FWFT)
//   empty, full, almost_empty, almost_full, count - registered status
//   overflow, underflow - sticky error flags
//
// Handshake: a request is an (cs & wr_en) or (cs & rd_en) sampled on the rising
// edge. It is accepted only if the FIFO is not full (write) / not empty (read)
// as seen before that edge; an accepted read and a rejected write (or vice
// versa) in the same cycle are handled independently. Rejected requests are
// dropped and only leave a trace in overflow/underflow.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = MODE_STD
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cs,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              clr_err,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              empty,
  output logic                              full,
  output logic                              almost_empty,
  output logic                              almost_full,
  output logic [count_width(FIFO_DEPTH)-1:0] count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int CW = count_width(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ov_set;
  logic                  un_set;
  logic [DATA_WIDTH-1:0] rd_data;

  // Acceptance uses the registered flags, i.e. the pre-edge occupancy.
  always_comb begin
    wr_acc    = cs & wr_en & ~full;
    rd_acc    = cs & rd_en & ~empty;
    ov_set    = cs & wr_en & full;
    un_set    = cs & rd_en & empty;
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are decoded from the next count so they are plain registers that
  // move on the same edge as count itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      overflow     <= ov_set | (overflow & ~clr_err);
      underflow    <= un_set | (underflow & ~clr_err);
    end
  end

  fifo_mem #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head entry is shown directly; forced to zero while empty so stale
      // memory never leaks out.
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (rd_acc) begin
          data_q <= rd_data;
        end
      end
      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: directed bench for fifo_thresh. Two instances share clk and
// rst_n: u_std (defaults, standard read mode) and u_ff (FWFT=1, AE_LEVEL=2).
module tb_fifo_thresh;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- standard-mode instance ----------------
  logic        s_cs = 0, s_wr = 0, s_rd = 0, s_clr = 0;
  logic [31:0] s_din = '0;
  logic [31:0] s_dout;
  logic        s_empty, s_full, s_ae, s_af, s_ov, s_un;
  logic [3:0]  s_count;

  fifo_thresh u_std (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (s_cs),
    .wr_en        (s_wr),
    .rd_en        (s_rd),
    .data_in      (s_din),
    .clr_err      (s_clr),
    .data_out     (s_dout),
    .empty        (s_empty),
    .full         (s_full),
    .almost_empty (s_ae),
    .almost_full  (s_af),
    .count        (s_count),
    .overflow     (s_ov),
    .underflow    (s_un)
  );

  // ---------------- FWFT instance ----------------
  logic        f_cs = 0, f_wr = 0, f_rd = 0, f_clr = 0;
  logic [31:0] f_din = '0;
  logic [31:0] f_dout;
  logic        f_empty, f_full, f_ae, f_af, f_ov, f_un;
  logic [3:0]  f_count;

  fifo_thresh #(
    .FIFO_DEPTH (8),
    .DATA_WIDTH (32),
    .AE_LEVEL   (2),
    .FWFT       (1)
  ) u_ff (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (f_cs),
    .wr_en        (f_wr),
    .rd_en        (f_rd),
    .data_in      (f_din),
    .clr_err      (f_clr),
    .data_out     (f_dout),
    .empty        (f_empty),
    .full         (f_full),
    .almost_empty (f_ae),
    .almost_full  (f_af),
    .count        (f_count),
    .overflow     (f_ov),
    .underflow    (f_un)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Each task is entered 1 time unit after a rising edge, drives for exactly
  // one edge and returns 1 time unit after it, so outputs are sampled away
  // from the edge.
  task automatic s_cycle(input logic c, input logic w, input logic r,
                         input logic [31:0] d, input logic clr);
    s_cs = c; s_wr = w; s_rd = r; s_din = d; s_clr = clr;
    @(posedge clk); #1;
    s_cs = 0; s_wr = 0; s_rd = 0; s_clr = 0;
  endtask

  task automatic f_cycle(input logic c, input logic w, input logic r,
                         input logic [31:0] d, input logic clr);
    f_cs = c; f_wr = w; f_rd = r; f_din = d; f_clr = clr;
    @(posedge clk); #1;
    f_cs = 0; f_wr = 0; f_rd = 0; f_clr = 0;
  endtask

  task automatic s_push(input logic [31:0] d);
    s_cycle(1, 1, 0, d, 0);
    exp_q.push_back(d);
  endtask

  task automatic s_pop(input string tag);
    logic [31:0] e;
    s_cycle(1, 0, 1, '0, 0);
    e = exp_q.pop_front();
    check(tag, s_dout, e);
  endtask

  // Simultaneous write+read; wr_ok/rd_ok are the hand-known acceptances.
  task automatic s_both(input logic [31:0] d, input logic wr_ok, input logic rd_ok, input string tag);
    logic [31:0] e;
    s_cycle(1, 1, 1, d, 0);
    if (rd_ok) begin
      e = exp_q.pop_front();
      check(tag, s_dout, e);
    end
    if (wr_ok) exp_q.push_back(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",  s_dout, 0);
    check("rst_count", 32'(s_count), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_ae",    32'(s_ae), 1);
    check("rst_full",  32'(s_full), 0);
    check("rst_af",    32'(s_af), 0);
    check("rst_ov",    32'(s_ov), 0);
    check("rst_un",    32'(s_un), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset mid-fill at count=5
    for (int i = 0; i < 5; i++) s_push(32'h50 + 32'(i));
    check("midfill_count", 32'(s_count), 5);
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(s_count), 0);
    check("midrst_empty", 32'(s_empty), 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write 1, 10, 100 then read back
    s_push(1); s_push(10); s_push(100);
    check("w3_count", 32'(s_count), 3);
    s_pop("rd_1");
    check("rd1_count", 32'(s_count), 2);
    s_pop("rd_10");
    check("rd2_count", 32'(s_count), 1);
    s_pop("rd_100");
    check("rd3_count", 32'(s_count), 0);
    check("rd3_empty", 32'(s_empty), 1);

    // fill/drain twice; pointers start at 3 so both passes cross the wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        s_push((pass == 0) ? (32'd1 << i) : (32'h100 + 32'(i)));
        check($sformatf("fill%0d_af_%0d", pass, i), 32'(s_af), (i >= 6) ? 1 : 0);
        check($sformatf("fill%0d_ae_%0d", pass, i), 32'(s_ae), (i == 0) ? 1 : 0);
      end
      check($sformatf("fill%0d_full", pass), 32'(s_full), 1);
      check($sformatf("fill%0d_count", pass), 32'(s_count), 8);
      s_cycle(1, 1, 0, 32'hDEAD, 0);
      check($sformatf("ovf%0d_flag", pass), 32'(s_ov), 1);
      check($sformatf("ovf%0d_count", pass), 32'(s_count), 8);
      for (int i = 0; i < 8; i++) s_pop($sformatf("drain%0d_%0d", pass, i));
      check($sformatf("drain%0d_empty", pass), 32'(s_empty), 1);
      check($sformatf("drain%0d_un", pass), 32'(s_un), 0);
      s_cycle(1, 0, 0, '0, 1);
      check($sformatf("clr%0d_ov", pass), 32'(s_ov), 0);
    end

    // simultaneous write+read at count=4
    for (int i = 0; i < 4; i++) s_push(32'hC0 + 32'(i));
    s_both(32'hC4, 1, 1, "both4_dout");
    check("both4_count", 32'(s_count), 4);
    for (int i = 0; i < 4; i++) s_pop($sformatf("both4_drain_%0d", i));
    check("both4_empty", 32'(s_empty), 1);

    // at count=0: write accepted, read rejected
    s_both(32'hD0, 1, 0, "both0");
    check("both0_count", 32'(s_count), 1);
    check("both0_un", 32'(s_un), 1);
    check("both0_ov", 32'(s_ov), 0);
    s_cycle(1, 0, 0, '0, 1);
    check("both0_clr", 32'(s_un), 0);

    // at count=8: read accepted, write rejected
    for (int i = 1; i < 8; i++) s_push(32'hD0 + 32'(i));
    check("both8_pre_full", 32'(s_full), 1);
    s_both(32'hEE, 0, 1, "both8_dout");
    check("both8_count", 32'(s_count), 7);
    check("both8_ov", 32'(s_ov), 1);
    s_cycle(1, 0, 0, '0, 1);
    for (int i = 0; i < 7; i++) s_pop($sformatf("both8_drain_%0d", i));
    check("both8_empty", 32'(s_empty), 1);

    // cs=0 blocks everything, including error flags
    s_cycle(0, 1, 1, 32'h99, 0);
    check("cs0_empty_un", 32'(s_un), 0);
    s_push(32'h11); s_push(32'h22);
    for (int i = 0; i < 4; i++) s_cycle(0, 1, 1, 32'h77, 0);
    check("cs0_count", 32'(s_count), 2);
    check("cs0_ov", 32'(s_ov), 0);
    check("cs0_un", 32'(s_un), 0);
    check("cs0_dout", s_dout, 32'hD7);
    s_pop("cs0_pop_11");
    s_pop("cs0_pop_22");
    check("cs0_end_empty", 32'(s_empty), 1);

    // ---------------- FWFT instance ----------------
    check("ff_rst_empty", 32'(f_empty), 1);
    f_cycle(1, 1, 0, 32'hA5, 0);
    check("ff_vis_dout", f_dout, 32'hA5);
    check("ff_vis_empty", 32'(f_empty), 0);
    check("ff_vis_count", 32'(f_count), 1);
    f_cycle(0, 0, 0, '0, 0);
    check("ff_hold_dout", f_dout, 32'hA5);
    f_cycle(1, 0, 1, '0, 0);
    check("ff_pop_empty", 32'(f_empty), 1);
    check("ff_pop_count", 32'(f_count), 0);
    f_cycle(1, 0, 1, '0, 0);
    check("ff_un_set", 32'(f_un), 1);
    f_cycle(1, 0, 0, '0, 1);
    check("ff_un_clr", 32'(f_un), 0);
    f_cycle(1, 0, 1, '0, 1);
    check("ff_set_wins", 32'(f_un), 1);
    f_cycle(1, 0, 0, '0, 1);
    check("ff_un_clr2", 32'(f_un), 0);

    // AE_LEVEL=2: almost_empty drops exactly at count=3
    f_cycle(1, 1, 0, 32'hB0, 0);
    check("ff_ae_c1", 32'(f_ae), 1);
    f_cycle(1, 1, 0, 32'hB1, 0);
    check("ff_ae_c2", 32'(f_ae), 1);
    f_cycle(1, 1, 0, 32'hB2, 0);
    check("ff_ae_c3", 32'(f_ae), 0);
    check("ff_head_b0", f_dout, 32'hB0);
    f_cycle(1, 0, 1, '0, 0);
    check("ff_ae_back", 32'(f_ae), 1);
    check("ff_head_b1", f_dout, 32'hB1);
    f_cycle(1, 0, 1, '0, 0);
    check("ff_head_b2", f_dout, 32'hB2);
    f_cycle(1, 0, 1, '0, 0);
    check("ff_final_empty", 32'(f_empty), 1);
    check("ff_ov_never", 32'(f_ov), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
